// File: rtl/riscv_pmachk_pipe.sv
// riscv_pmachk_pipe: registered PMA checker.
// A shadow copy of the PMA table is captured by a sequential loader, one region
// per cycle, with region bounds precomputed at load time. Accesses are then
// checked against the shadow table in a single-stage valid/ready pipe, so the
// bound/priority logic no longer sits on the fetch/LSU timing arc.
// Optional feature: define RISCV_PMACHK_ERRCNT_EN to build the saturating
// exception counter on err_cnt_o (otherwise err_cnt_o is tied to zero).

package riscv_pmachk_pkg;
    typedef enum logic [1:0] {
        MEM_TYPE_EMPTY = 2'b00,
        MEM_TYPE_MAIN  = 2'b01,
        MEM_TYPE_IO    = 2'b10,
        MEM_TYPE_TCM   = 2'b11
    } mem_type_t;

    typedef enum logic [1:0] {
        PMA_OFF   = 2'b00,
        PMA_TOR   = 2'b01,
        PMA_NA4   = 2'b10,
        PMA_NAPOT = 2'b11
    } pma_a_t;

    typedef struct packed {
        mem_type_t mem_type;
        logic      r;
        logic      w;
        logic      x;
        logic      c;
        logic      cc;
        logic      ri;
        logic      wi;
        logic      m;
        pma_a_t    a;
    } pmacfg_t;

    typedef enum logic [2:0] {
        BIU_BYTE  = 3'd0,
        BIU_HWORD = 3'd1,
        BIU_WORD  = 3'd2,
        BIU_DWORD = 3'd3,
        BIU_QWORD = 3'd4
    } biu_size_t;
endpackage

module riscv_pmachk_pipe
    import riscv_pmachk_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PLEN    = (XLEN == 32) ? 34 : 56,
    parameter int PMA_CNT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  pmacfg_t           pma_cfg_i [PMA_CNT],
    input  logic [XLEN-1:0]   pma_adr_i [PMA_CNT],
    input  logic              cfg_update_i,
    output logic              cfg_busy_o,
    input  logic              req_i,
    output logic              ready_o,
    input  logic              instruction_i,
    input  logic [PLEN-1:0]   adr_i,
    input  biu_size_t         size_i,
    input  logic              we_i,
    input  logic              misaligned_i,
    output logic              valid_o,
    input  logic              ready_i,
    output pmacfg_t           pma_o,
    output logic              exception_o,
    output logic              misaligned_o,
    output logic              is_cache_access_o,
    output logic              is_ext_access_o,
    output logic              is_tcm_access_o,
    output logic [31:0]       err_cnt_o
);

    // Bounds are kept word-granular (address bits PLEN-1:2).
    localparam int AW = PLEN - 2;
    localparam int IW = (PMA_CNT > 1) ? $clog2(PMA_CNT) : 1;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Cleans up a raw cfg entry: EMPTY behaves as inaccessible IO, only MAIN
    // may be cacheable, cc needs c, and ri/wi are only meaningful for IO.
    function automatic pmacfg_t sanitise(input pmacfg_t raw);
        pmacfg_t s;
        s = raw;
        if (raw.mem_type == MEM_TYPE_EMPTY) begin
            s.mem_type = MEM_TYPE_IO;
            s.r        = 1'b0;
            s.w        = 1'b0;
            s.x        = 1'b0;
        end else begin
            s.mem_type = raw.mem_type;
        end
        s.c  = raw.c & (raw.mem_type == MEM_TYPE_MAIN);
        s.cc = raw.cc & s.c;
        if (s.mem_type != MEM_TYPE_IO) begin
            s.ri = 1'b1;
            s.wi = 1'b1;
        end else begin
            s.ri = raw.ri;
            s.wi = raw.wi;
        end
        return s;
    endfunction

    // Number of bytes covered by a transfer of the given size.
    function automatic logic [PLEN-1:0] size_bytes(input biu_size_t sz);
        logic [PLEN-1:0] n;
        case (sz)
            BIU_BYTE:  n = PLEN'(5'd1);
            BIU_HWORD: n = PLEN'(5'd2);
            BIU_WORD:  n = PLEN'(5'd4);
            BIU_DWORD: n = PLEN'(5'd8);
            BIU_QWORD: n = PLEN'(5'd16);
            default:   n = PLEN'(5'd1);
        endcase
        return n;
    endfunction

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic            r_pending;
    pmacfg_t         r_cfg [PMA_CNT];
    logic [AW-1:0]   r_lb  [PMA_CNT];
    logic [AW-1:0]   r_ub  [PMA_CNT];

    logic            r_valid;
    pmacfg_t         r_pma;
    logic            r_exc;
    logic            r_mis;
    logic            r_cache;
    logic            r_ext;
    logic            r_tcm;

    logic [AW-1:0]   w_ld_adr;
    logic [AW-1:0]   w_ld_prev_ub;
    logic [AW-1:0]   w_ld_lb;
    logic [AW-1:0]   w_ld_ub;
    pmacfg_t         w_ld_cfg;

    logic [PLEN-1:0] w_acc_end;
    logic [AW-1:0]   w_acc_lb;
    logic [AW-1:0]   w_acc_ub;
    logic [PMA_CNT-1:0] w_match;
    logic            w_hit;
    pmacfg_t         w_hit_cfg;
    logic            w_exc;
    logic            w_mis;
    logic            w_ready;
    logic            w_accept;
    logic            w_update;

    assign w_ready    = (r_state == ST_RUN) & ~r_pending & (~r_valid | ready_i);
    assign w_accept   = req_i & w_ready;
    assign w_update   = cfg_update_i | r_pending;
    assign ready_o    = w_ready;
    assign cfg_busy_o = (r_state == ST_LOAD);

    // Bound precomputation for the region currently addressed by the loader.
    always_comb begin
        w_ld_adr     = AW'(pma_adr_i[r_idx]);
        w_ld_cfg     = sanitise(pma_cfg_i[r_idx]);
        w_ld_prev_ub = (r_idx == IW'(0)) ? AW'(1'b0) : r_ub[r_idx - IW'(1)];
        case (pma_cfg_i[r_idx].a)
            PMA_TOR: begin
                w_ld_lb = w_ld_prev_ub;
                w_ld_ub = w_ld_adr;
            end
            PMA_NA4: begin
                w_ld_lb = w_ld_adr;
                w_ld_ub = w_ld_adr + AW'(1'b1);
            end
            PMA_NAPOT: begin
                // Clearing the trailing ones gives the base; setting the lowest
                // zero and adding one gives the exclusive top.
                w_ld_lb = w_ld_adr & (w_ld_adr + AW'(1'b1));
                w_ld_ub = (w_ld_adr | (w_ld_adr + AW'(1'b1))) + AW'(1'b1);
            end
            default: begin
                // OFF never matches; keep the address as ub so a following TOR
                // region sees the raw register as its lower bound.
                w_ld_lb = AW'(1'b0);
                w_ld_ub = w_ld_adr;
            end
        endcase
    end

    // Word-granular access span; a span wrapping past the top is rejected.
    always_comb begin
        w_acc_end = adr_i + size_bytes(size_i) - PLEN'(1'b1);
        w_acc_lb  = adr_i[PLEN-1:2];
        w_acc_ub  = AW'(w_acc_end >> 2);
        for (int k = 0; k < PMA_CNT; k++) begin
            w_match[k] = (r_cfg[k].a != PMA_OFF) & (r_lb[k] <= w_acc_lb) &
                         (w_acc_ub < r_ub[k]) & (w_acc_lb <= w_acc_ub);
        end
    end

    // Priority select: walking downward leaves the lowest matching index.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_cfg = '0;
        for (int k = PMA_CNT - 1; k >= 0; k--) begin
            w_hit     = w_match[k] | w_hit;
            w_hit_cfg = w_match[k] ? r_cfg[k] : w_hit_cfg;
        end
        w_exc = ~w_hit | (instruction_i & ~w_hit_cfg.x) | (we_i & ~w_hit_cfg.w) |
                (~we_i & ~w_hit_cfg.r);
        w_mis = misaligned_i & ~w_hit_cfg.m;
    end

    // Loader / run FSM including the shadow table and deferred-update flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_LOAD;
            r_idx     <= IW'(0);
            r_pending <= 1'b0;
            for (int k = 0; k < PMA_CNT; k++) begin
                r_cfg[k] <= '0;
                r_lb[k]  <= AW'(1'b0);
                r_ub[k]  <= AW'(1'b0);
            end
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_pending <= 1'b0;
                    if (cfg_update_i) begin
                        r_idx <= IW'(0);
                    end else begin
                        r_cfg[r_idx] <= w_ld_cfg;
                        r_lb[r_idx]  <= w_ld_lb;
                        r_ub[r_idx]  <= w_ld_ub;
                        if (r_idx == IW'(PMA_CNT - 1)) begin
                            r_state <= ST_RUN;
                            r_idx   <= IW'(0);
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    // Reload only once the output stage is empty or drains now
                    // and nothing new is being accepted this cycle.
                    if (w_update & ~w_accept & (~r_valid | ready_i)) begin
                        r_state   <= ST_LOAD;
                        r_idx     <= IW'(0);
                        r_pending <= 1'b0;
                    end else if (cfg_update_i) begin
                        r_pending <= 1'b1;
                    end else begin
                        r_pending <= r_pending;
                    end
                end
                default: begin
                    r_state   <= ST_LOAD;
                    r_idx     <= IW'(0);
                    r_pending <= 1'b0;
                end
            endcase
        end
    end

    // Result stage: capture on accept, drop on consume, hold while stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_pma   <= '0;
            r_exc   <= 1'b0;
            r_mis   <= 1'b0;
            r_cache <= 1'b0;
            r_ext   <= 1'b0;
            r_tcm   <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_pma   <= w_hit ? w_hit_cfg : '0;
            r_exc   <= w_exc;
            r_mis   <= w_mis;
            r_cache <= ~w_exc & ~w_mis & w_hit_cfg.c;
            r_tcm   <= ~w_exc & ~w_mis & (w_hit_cfg.mem_type == MEM_TYPE_TCM);
            r_ext   <= ~w_exc & ~w_mis & ~w_hit_cfg.c & (w_hit_cfg.mem_type != MEM_TYPE_TCM);
        end else if (r_valid & ready_i) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign valid_o           = r_valid;
    assign pma_o             = r_pma;
    assign exception_o       = r_exc;
    assign misaligned_o      = r_mis;
    assign is_cache_access_o = r_cache;
    assign is_ext_access_o   = r_ext;
    assign is_tcm_access_o   = r_tcm;

`ifdef RISCV_PMACHK_ERRCNT_EN
    logic [31:0] r_err_cnt;

    // Saturating count of consumed results that carried an exception.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_cnt <= 32'h0;
        end else if (r_valid & ready_i & r_exc & (r_err_cnt != 32'hFFFF_FFFF)) begin
            r_err_cnt <= r_err_cnt + 32'h1;
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    assign err_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_riscv_pmachk_pipe.sv
// Directed self-checking bench for riscv_pmachk_pipe (PMA_CNT=16, PLEN=34).
module tb_riscv_pmachk_pipe;
    import riscv_pmachk_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    pmacfg_t     pma_cfg [16];
    logic [31:0] pma_adr [16];
    logic        cfg_update;
    logic        cfg_busy;
    logic        req;
    logic        ready_o;
    logic        instr;
    logic [33:0] adr;
    biu_size_t   size;
    logic        we;
    logic        misal;
    logic        valid_o;
    logic        ready_i;
    pmacfg_t     pma_o;
    logic        exc_o, mis_o, cache_o, ext_o, tcm_o;
    logic [31:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_err = 0;

    pmacfg_t e2, e3, e_r1, e_r3;

    riscv_pmachk_pipe #(.XLEN(32), .PLEN(34), .PMA_CNT(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .pma_cfg_i(pma_cfg), .pma_adr_i(pma_adr),
        .cfg_update_i(cfg_update), .cfg_busy_o(cfg_busy), .req_i(req), .ready_o(ready_o),
        .instruction_i(instr), .adr_i(adr), .size_i(size), .we_i(we), .misaligned_i(misal),
        .valid_o(valid_o), .ready_i(ready_i), .pma_o(pma_o), .exception_o(exc_o),
        .misaligned_o(mis_o), .is_cache_access_o(cache_o), .is_ext_access_o(ext_o),
        .is_tcm_access_o(tcm_o), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic pmacfg_t mk(input mem_type_t t, input logic r, input logic w,
                                   input logic x, input logic c, input logic cc,
                                   input logic ri, input logic wi, input logic m,
                                   input pma_a_t a);
        pmacfg_t p;
        p.mem_type = t; p.r = r; p.w = w; p.x = x; p.c = c;
        p.cc = cc; p.ri = ri; p.wi = wi; p.m = m; p.a = a;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the loader; it must take exactly 16 cycles.
    task automatic wait_load(input string tag);
        int n;
        n = 0;
        chk({tag, ".busy"}, cfg_busy, 1);
        while (cfg_busy && n < 40) begin
            tick();
            n++;
        end
        chk({tag, ".len"}, n, 16);
        chk({tag, ".ready"}, ready_o, 1);
    endtask

    task automatic reload(input string tag);
        cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
        wait_load(tag);
    endtask

    task automatic clear_cfg();
        for (int k = 0; k < 16; k++) begin
            pma_cfg[k] = '0;
            pma_adr[k] = 32'h0;
        end
    endtask

    // Issue one request and step to the cycle its result is visible.
    task automatic acc(input string tag, input logic ins, input logic [33:0] a,
                       input biu_size_t sz, input logic wr, input logic mis);
        req = 1'b1; instr = ins; adr = a; size = sz; we = wr; misal = mis;
        chk({tag, ".rdy"}, ready_o, 1);
        tick();
        req = 1'b0;
        chk({tag, ".valid"}, valid_o, 1);
    endtask

    // Check the held result, let it be consumed, then check the counter.
    task automatic res(input string tag, input logic e_exc, input logic e_mis,
                       input logic e_cache, input logic e_ext, input logic e_tcm,
                       input pmacfg_t e_pma);
        chk({tag, ".exc"}, exc_o, e_exc);
        chk({tag, ".mis"}, mis_o, e_mis);
        chk({tag, ".cache"}, cache_o, e_cache);
        chk({tag, ".ext"}, ext_o, e_ext);
        chk({tag, ".tcm"}, tcm_o, e_tcm);
        chk({tag, ".pma"}, pma_o, e_pma);
        tick();
`ifdef RISCV_PMACHK_ERRCNT_EN
        if (e_exc) exp_err++;
`endif
        chk({tag, ".drop"}, valid_o, 0);
        chk({tag, ".err"}, err_cnt, exp_err);
    endtask

    initial begin
        rst_i = 1'b1; cfg_update = 1'b0; req = 1'b0; instr = 1'b0; adr = 34'h0;
        size = BIU_WORD; we = 1'b0; misal = 1'b0; ready_i = 1'b1;
        clear_cfg();
        repeat (3) tick();
        chk("rst.valid", valid_o, 0);
        chk("rst.pma", pma_o, 0);
        chk("rst.exc", exc_o, 0);
        chk("rst.err", err_cnt, 0);
        rst_i = 1'b0;
        // Auto-load after reset: busy for 16 cycles, ready in cycle 17.
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("boot.busy%0d", i), cfg_busy, 1);
            chk($sformatf("boot.nrdy%0d", i), ready_o, 0);
            tick();
        end
        chk("boot.idle", cfg_busy, 0);
        chk("boot.ready", ready_o, 1);

        // Region0 NAPOT 0..0x1FFF MAIN rwx c cc; ri/wi forced to 1.
        pma_cfg[0] = mk(MEM_TYPE_MAIN, 1, 1, 1, 1, 1, 0, 0, 0, PMA_NAPOT);
        pma_adr[0] = 32'h0000_03FF;
        e2 = mk(MEM_TYPE_MAIN, 1, 1, 1, 1, 1, 1, 1, 0, PMA_NAPOT);
        reload("ld2");
        acc("napot_in", 0, 34'h0_0000_1FFC, BIU_WORD, 0, 0);
        res("napot_in", 0, 0, 1, 0, 0, e2);
        acc("napot_out", 0, 34'h0_0000_2000, BIU_WORD, 0, 0);
        res("napot_out", 1, 0, 0, 0, 0, '0);
        acc("napot_mis", 1, 34'h0_0000_0100, BIU_WORD, 0, 1);
        res("napot_mis", 0, 1, 0, 0, 0, e2);

        // Region0 TOR 0..0xFFF IO r only, m=1; c/cc stripped, ri/wi kept.
        pma_cfg[0] = mk(MEM_TYPE_IO, 1, 0, 0, 1, 1, 1, 0, 1, PMA_TOR);
        pma_adr[0] = 32'h0000_0400;
        e3 = mk(MEM_TYPE_IO, 1, 0, 0, 0, 0, 1, 0, 1, PMA_TOR);
        reload("ld3");
        acc("tor_wr", 0, 34'h0_0000_0FFC, BIU_WORD, 1, 0);
        res("tor_wr", 1, 0, 0, 0, 0, e3);
        acc("tor_rd", 0, 34'h0_0000_0FFC, BIU_WORD, 0, 0);
        res("tor_rd", 0, 0, 0, 1, 0, e3);
        acc("tor_straddle", 0, 34'h0_0000_0FFC, BIU_DWORD, 0, 0);
        res("tor_straddle", 1, 0, 0, 0, 0, '0);
        acc("tor_fetch", 1, 34'h0_0000_0000, BIU_WORD, 0, 0);
        res("tor_fetch", 1, 0, 0, 0, 0, e3);
        acc("tor_mis", 0, 34'h0_0000_0FF0, BIU_HWORD, 0, 1);
        res("tor_mis", 0, 0, 0, 1, 0, e3);

        // Region1 NA4 TCM at 0x800, region3 NAPOT MAIN 0..0xFFF over it.
        clear_cfg();
        pma_cfg[1] = mk(MEM_TYPE_TCM, 1, 1, 1, 0, 0, 0, 0, 0, PMA_NA4);
        pma_adr[1] = 32'h0000_0200;
        pma_cfg[3] = mk(MEM_TYPE_MAIN, 1, 1, 1, 1, 0, 0, 0, 0, PMA_NAPOT);
        pma_adr[3] = 32'h0000_01FF;
        e_r1 = mk(MEM_TYPE_TCM, 1, 1, 1, 0, 0, 1, 1, 0, PMA_NA4);
        e_r3 = mk(MEM_TYPE_MAIN, 1, 1, 1, 1, 0, 1, 1, 0, PMA_NAPOT);
        reload("ld4");
        acc("ovl_tcm", 0, 34'h0_0000_0800, BIU_WORD, 0, 0);
        res("ovl_tcm", 0, 0, 0, 0, 1, e_r1);
        acc("ovl_main", 0, 34'h0_0000_0804, BIU_WORD, 1, 0);
        res("ovl_main", 0, 0, 1, 0, 0, e_r3);
        acc("ovl_span", 0, 34'h0_0000_07FF, BIU_HWORD, 0, 0);
        res("ovl_span", 0, 0, 1, 0, 0, e_r3);
        acc("top_in", 0, 34'h0_0000_0FFF, BIU_BYTE, 0, 0);
        res("top_in", 0, 0, 1, 0, 0, e_r3);
        acc("top_out", 0, 34'h0_0000_1000, BIU_BYTE, 0, 0);
        res("top_out", 1, 0, 0, 0, 0, '0);
        acc("wrap", 0, 34'h3_FFFF_FFFC, BIU_DWORD, 0, 0);
        res("wrap", 1, 0, 0, 0, 0, '0);

        // Back-to-back: accept and consume in the same cycle.
        req = 1'b1; instr = 1'b0; adr = 34'h0_0000_0800; size = BIU_WORD; we = 1'b0; misal = 1'b0;
        chk("b2b.rdy0", ready_o, 1);
        tick();
        adr = 34'h0_0000_0804;
        chk("b2b.tcm", tcm_o, 1);
        chk("b2b.rdy1", ready_o, 1);
        tick();
        req = 1'b0;
        chk("b2b.valid", valid_o, 1);
        chk("b2b.cache", cache_o, 1);
        chk("b2b.pma", pma_o, e_r3);
        tick();
        chk("b2b.drop", valid_o, 0);

        // Stalled fault is only counted once consumed.
        ready_i = 1'b0;
        acc("sfault", 0, 34'h0_0000_2000, BIU_WORD, 0, 0);
        for (int i = 0; i < 2; i++) begin
            chk("sfault.hold_err", err_cnt, exp_err);
            chk("sfault.hold_v", valid_o, 1);
            tick();
        end
        ready_i = 1'b1;
        res("sfault", 1, 0, 0, 0, 0, '0);

        // Backpressure with an update arriving mid-stall.
        ready_i = 1'b0;
        acc("bp", 0, 34'h0_0000_0800, BIU_WORD, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp.valid%0d", i), valid_o, 1);
            chk($sformatf("bp.tcm%0d", i), tcm_o, 1);
            chk($sformatf("bp.pma%0d", i), pma_o, e_r1);
            chk($sformatf("bp.nrdy%0d", i), ready_o, 0);
            cfg_update = (i == 2);
            tick();
        end
        cfg_update = 1'b0;
        chk("bp.nbusy", cfg_busy, 0);
        ready_i = 1'b1;
        chk("bp.pend_nrdy", ready_o, 0);
        tick();
        chk("bp.drop", valid_o, 0);
        wait_load("bp.ld");

        // Request and update together: request wins, update is deferred.
        req = 1'b1; adr = 34'h0_0000_0804; size = BIU_WORD; we = 1'b0;
        cfg_update = 1'b1;
        chk("sim.rdy", ready_o, 1);
        tick();
        req = 1'b0; cfg_update = 1'b0;
        chk("sim.valid", valid_o, 1);
        chk("sim.cache", cache_o, 1);
        chk("sim.nbusy", cfg_busy, 0);
        chk("sim.nrdy", ready_o, 0);
        tick();
        chk("sim.drop", valid_o, 0);
        wait_load("sim.ld");
        chk("final.err", err_cnt, exp_err);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
